// File: rtl/dvi_sync_detect.sv
// Sink-side DVI timing recovery: turns hsync/vsync/de into pixel coordinates,
// measures line/frame geometry and raises locked_o once that geometry is stable.
module dvi_sync_detect #(
  parameter int X_POS_W         = 11,
  parameter int Y_POS_W         = 10,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int LOCK_FRAMES     = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               hsync_i,
  input  logic               vsync_i,
  input  logic               de_i,
  output logic               de_o,
  output logic [X_POS_W-1:0] pixel_x_o,
  output logic [Y_POS_W-1:0] pixel_y_o,
  output logic               frame_start_o,
  output logic               locked_o,
  output logic [X_POS_W-1:0] h_total_o,
  output logic [X_POS_W-1:0] h_active_o,
  output logic [Y_POS_W-1:0] v_total_o,
  output logic [Y_POS_W-1:0] v_active_o
);
  localparam logic [X_POS_W-1:0] X_MAX = '1;
  localparam logic [Y_POS_W-1:0] Y_MAX = '1;
  localparam int                 MC_W  = $clog2(LOCK_FRAMES + 1);
  localparam logic [MC_W-1:0]    MC_LOCK = MC_W'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  function automatic logic [X_POS_W-1:0] x_inc(input logic [X_POS_W-1:0] v);
    x_inc = (v == X_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [Y_POS_W-1:0] y_inc(input logic [Y_POS_W-1:0] v);
    y_inc = (v == Y_MAX) ? v : v + 1'b1;
  endfunction

  // Sync stages hold the "asserted" level, so polarity is resolved at the pin.
  logic hs1, hs2, vs1, vs2, de1, de2;
  logic line_ev, frame_ev, de_first, de_fall;

  logic [X_POS_W-1:0] h_cnt, h_act_cnt;
  logic               line_de;
  logic [Y_POS_W-1:0] v_cnt, v_act_cnt, y_cnt;

  logic               frm_first, frm_bad;
  logic [X_POS_W-1:0] frm_htot, frm_hact;

  state_t             state;
  logic [MC_W-1:0]    match_cnt, mc_next;

  logic [X_POS_W-1:0] f_htot, f_hact;
  logic [Y_POS_W-1:0] f_vtot, f_vact;
  logic               line_bad, f_bad, lock_line_bad, sample_eq;
  logic               h_to, v_to, timeout;

  assign line_ev  = hs1 & ~hs2;
  assign frame_ev = vs1 & ~vs2;
  assign de_first = de1 & ~de2;
  assign de_fall  = de2 & ~de1;
  assign mc_next  = MC_W'(match_cnt + 1'b1);

  // Frame summary as it would stand if this cycle's line closed the frame,
  // so a coincident line event is folded into the ending frame.
  always_comb begin
    f_htot   = frm_htot;
    f_hact   = frm_hact;
    line_bad = 1'b0;
    if (line_ev) begin
      if (frm_first)
        f_htot = h_cnt;
      else if (h_cnt != frm_htot)
        line_bad = 1'b1;
      if (h_act_cnt != '0) begin
        if (frm_hact == '0)
          f_hact = h_act_cnt;
        else if (h_act_cnt != frm_hact)
          line_bad = 1'b1;
      end
    end
    f_vtot = line_ev ? y_inc(v_cnt) : v_cnt;
    f_vact = (line_ev && line_de) ? y_inc(v_act_cnt) : v_act_cnt;
    f_bad  = frm_bad | line_bad;

    lock_line_bad = line_ev &&
                    ((h_cnt != h_total_o) ||
                     ((h_act_cnt != '0) && (h_act_cnt != h_active_o)));
    sample_eq = ({f_htot, f_hact, f_vtot, f_vact} ==
                 {h_total_o, h_active_o, v_total_o, v_active_o});

    // One-shot on the cycle a counter reaches saturation, so a long-idle
    // counter does not swallow the first real event after the gap.
    h_to    = !line_ev && (h_cnt == X_MAX - 1'b1);
    v_to    = !frame_ev && line_ev && (v_cnt == Y_MAX - 1'b1);
    timeout = h_to | v_to;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hs1 <= 1'b0; hs2 <= 1'b0;
      vs1 <= 1'b0; vs2 <= 1'b0;
      de1 <= 1'b0; de2 <= 1'b0;
      de_o          <= 1'b0;
      pixel_x_o     <= '0;
      pixel_y_o     <= '0;
      frame_start_o <= 1'b0;
      y_cnt         <= '0;
      h_cnt         <= '0;
      h_act_cnt     <= '0;
      line_de       <= 1'b0;
      v_cnt         <= '0;
      v_act_cnt     <= '0;
      frm_first     <= 1'b1;
      frm_bad       <= 1'b0;
      frm_htot      <= '0;
      frm_hact      <= '0;
      state         <= SEARCH;
      match_cnt     <= '0;
      locked_o      <= 1'b0;
      h_total_o     <= '0;
      h_active_o    <= '0;
      v_total_o     <= '0;
      v_active_o    <= '0;
    end else begin
      hs1 <= hsync_i ^ SYNC_ACTIVE_LOW;
      vs1 <= vsync_i ^ SYNC_ACTIVE_LOW;
      de1 <= de_i;
      hs2 <= hs1;
      vs2 <= vs1;
      de2 <= de1;

      // Pixel coordinate pipeline
      de_o <= de1;
      if (de1) begin
        pixel_x_o <= de2 ? x_inc(pixel_x_o) : '0;
        pixel_y_o <= y_cnt;
      end
      frame_start_o <= de_first && (y_cnt == '0);
      if (frame_ev)
        y_cnt <= '0;
      else if (de_fall)
        y_cnt <= y_inc(y_cnt);

      // Line measurement; a de cycle coincident with hsync belongs to the new line
      if (line_ev) begin
        h_cnt     <= X_POS_W'(1);
        h_act_cnt <= de1 ? X_POS_W'(1) : '0;
        line_de   <= de1;
      end else begin
        h_cnt <= x_inc(h_cnt);
        if (de1) begin
          h_act_cnt <= x_inc(h_act_cnt);
          line_de   <= 1'b1;
        end
      end

      // Frame measurement
      if (frame_ev) begin
        v_cnt     <= '0;
        v_act_cnt <= '0;
        frm_first <= 1'b1;
        frm_bad   <= 1'b0;
        frm_htot  <= '0;
        frm_hact  <= '0;
      end else begin
        if (line_ev) begin
          v_cnt     <= f_vtot;
          v_act_cnt <= f_vact;
          frm_first <= 1'b0;
          frm_htot  <= f_htot;
          frm_hact  <= f_hact;
        end
        frm_bad <= f_bad;
      end

      case (state)
        SEARCH: begin
          if (frame_ev && !timeout) begin
            state     <= MEASURE;
            match_cnt <= '0;
          end
        end
        MEASURE: begin
          if (timeout) begin
            state     <= SEARCH;
            match_cnt <= '0;
          end else if (frame_ev) begin
            h_total_o  <= f_htot;
            h_active_o <= f_hact;
            v_total_o  <= f_vtot;
            v_active_o <= f_vact;
            if (f_bad) begin
              match_cnt <= '0;
            end else if (sample_eq) begin
              match_cnt <= mc_next;
              if (mc_next == MC_LOCK) begin
                state    <= LOCKED;
                locked_o <= 1'b1;
              end
            end else begin
              match_cnt <= MC_W'(1);
            end
          end else if (line_bad) begin
            match_cnt <= '0;
          end
        end
        LOCKED: begin
          if (timeout || lock_line_bad || (frame_ev && !sample_eq)) begin
            state     <= SEARCH;
            locked_o  <= 1'b0;
            match_cnt <= '0;
          end
        end
        default: begin
          state     <= SEARCH;
          locked_o  <= 1'b0;
          match_cnt <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dvi_sync_detect.sv
// Scoreboarded bench: stimulus pushes expected pixels, a monitor pops them off de_o;
// lock latency and geometry are checked inline against hand-computed values.
module tb_dvi_sync_detect;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic hs_a, vs_a, de_a, hs_b, vs_b, de_b;

  logic        deo_a, fs_a, lk_a, deo_b, fs_b, lk_b;
  logic [10:0] px_a, ht_a, ha_a, px_b, ht_b, ha_b;
  logic [9:0]  py_a, vt_a, va_a, py_b, vt_b, va_b;

  // A: active-low syncs, 50x14 total, 32x10 active
  dvi_sync_detect #(.X_POS_W(11), .Y_POS_W(10), .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .hsync_i(hs_a), .vsync_i(vs_a), .de_i(de_a),
    .de_o(deo_a), .pixel_x_o(px_a), .pixel_y_o(py_a), .frame_start_o(fs_a),
    .locked_o(lk_a), .h_total_o(ht_a), .h_active_o(ha_a), .v_total_o(vt_a), .v_active_o(va_a));

  // B: active-high syncs, 66x18 total, 48x12 active
  dvi_sync_detect #(.X_POS_W(11), .Y_POS_W(10), .SYNC_ACTIVE_LOW(1'b0), .LOCK_FRAMES(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .hsync_i(hs_b), .vsync_i(vs_b), .de_i(de_b),
    .de_o(deo_b), .pixel_x_o(px_b), .pixel_y_o(py_b), .frame_start_o(fs_b),
    .locked_o(lk_b), .h_total_o(ht_b), .h_active_o(ha_b), .v_total_o(vt_b), .v_active_o(va_b));

  typedef struct {int x; int y; bit fs;} pix_t;
  pix_t qa[$];
  pix_t qb[$];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    pix_t p;
    if (deo_a) begin
      if (qa.size() == 0) chk("a_unexpected_pixel", 1, 0);
      else begin
        p = qa.pop_front();
        chk("a_pixel_x", px_a, p.x);
        chk("a_pixel_y", py_a, p.y);
        chk("a_frame_start", fs_a, p.fs);
      end
    end else chk("a_frame_start_idle", fs_a, 0);
    if (deo_b) begin
      if (qb.size() == 0) chk("b_unexpected_pixel", 1, 0);
      else begin
        p = qb.pop_front();
        chk("b_pixel_x", px_b, p.x);
        chk("b_pixel_y", py_b, p.y);
        chk("b_frame_start", fs_b, p.fs);
      end
    end else chk("b_frame_start_idle", fs_b, 0);
  end

  task automatic chk_zero_a(input string tg);
    chk({tg, "_de_o"}, deo_a, 0);
    chk({tg, "_pixel_x"}, px_a, 0);
    chk({tg, "_pixel_y"}, py_a, 0);
    chk({tg, "_frame_start"}, fs_a, 0);
    chk({tg, "_locked"}, lk_a, 0);
    chk({tg, "_h_total"}, ht_a, 0);
    chk({tg, "_h_active"}, ha_a, 0);
    chk({tg, "_v_total"}, vt_a, 0);
    chk({tg, "_v_active"}, va_a, 0);
  endtask

  task automatic chk_meas(input bit sel, input string tg, input int ht, input int ha,
                          input int vt, input int va);
    chk({tg, "_h_total"},  sel ? ht_b : ht_a, ht);
    chk({tg, "_h_active"}, sel ? ha_b : ha_a, ha);
    chk({tg, "_v_total"},  sel ? vt_b : vt_a, vt);
    chk({tg, "_v_active"}, sel ? va_b : va_a, va);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame; each line starts with hsync, the frame with vsync. Optional:
  // shorten one line by a clock, check locked_o 1 and 2 clocks after a line's
  // hsync edge, pulse reset at cycle 20 of a line.
  task automatic run_frame(input bit sel, input int short_line, input int chk_line,
                           input int lk_pre, input int lk_post, input int rst_line);
    int ht, hsw, hbp, ha, vt, vsw, vbp, va;
    string tg;
    tg = sel ? "b" : "a";
    if (sel) begin ht = 66; hsw = 4; hbp = 6; ha = 48; vt = 18; vsw = 3; vbp = 1; va = 12; end
    else     begin ht = 50; hsw = 6; hbp = 7; ha = 32; vt = 14; vsw = 2; vbp = 1; va = 10; end
    for (int l = 0; l < vt; l++) begin
      for (int c = 0; c < ((l == short_line) ? ht - 1 : ht); c++) begin
        bit hv, vv, dv;
        pix_t p;
        @(negedge clk);
        if (l == chk_line && c == 1 && lk_pre >= 0)
          chk({tg, "_locked_edge_plus1"}, sel ? lk_b : lk_a, lk_pre);
        if (l == chk_line && c == 2 && lk_post >= 0)
          chk({tg, "_locked_edge_plus2"}, sel ? lk_b : lk_a, lk_post);
        if (l == rst_line && c == 21) chk_zero_a("a_midframe_reset");
        rst = (l == rst_line && c == 20);
        hv = (c < hsw);
        vv = (l < vsw);
        dv = (l >= vsw + vbp) && (l < vsw + vbp + va) && (c >= hsw + hbp) && (c < hsw + hbp + ha);
        if (sel) begin hs_b = hv; vs_b = vv; de_b = dv; end
        else     begin hs_a = !hv; vs_a = !vv; de_a = dv; end
        if (dv) begin
          p.x  = c - (hsw + hbp);
          p.y  = l - (vsw + vbp);
          p.fs = (p.x == 0) && (p.y == 0);
          if (sel) qb.push_back(p);
          else     qa.push_back(p);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    hs_a = 1'b1; vs_a = 1'b1; de_a = 1'b0;
    hs_b = 1'b0; vs_b = 1'b0; de_b = 1'b0;
    idle(3);
    chk_zero_a("a_reset");
    chk("b_reset_locked", lk_b, 0);
    rst = 1'b0;
    idle(4);

    // Lock from reset: rises 2 clk after the 3rd vsync edge
    run_frame(0, -1, -1, -1, -1, -1);
    run_frame(0, -1,  0,  0,  0, -1);
    run_frame(0, -1,  0,  0,  1, -1);
    chk_meas(0, "a_lock1", 50, 32, 14, 10);
    run_frame(0, -1,  0,  1,  1, -1);

    // One short line: drops 2 clk after the following hsync edge, relock on 3rd edge
    run_frame(0,  5,  6,  1,  0, -1);
    run_frame(0, -1,  0,  0,  0, -1);
    run_frame(0, -1,  0,  0,  0, -1);
    run_frame(0, -1,  0,  0,  1, -1);
    chk_meas(0, "a_relock", 50, 32, 14, 10);

    // hsync stalls: still locked before saturation, unlocked after, values held
    run_frame(0, -1,  0,  1,  1, -1);
    idle(1900);
    chk("a_locked_before_timeout", lk_a, 1);
    idle(200);
    chk("a_locked_after_timeout", lk_a, 0);
    chk_meas(0, "a_timeout_hold", 50, 32, 14, 10);
    run_frame(0, -1,  0,  0,  0, -1);
    run_frame(0, -1,  0,  0,  0, -1);
    run_frame(0, -1,  0,  0,  1, -1);

    // Reset mid-frame while locked, then relock
    run_frame(0, -1,  0,  1,  1,  2);
    run_frame(0, -1,  0,  0,  0, -1);
    run_frame(0, -1,  0,  0,  0, -1);
    run_frame(0, -1,  0,  0,  1, -1);
    chk_meas(0, "a_after_reset", 50, 32, 14, 10);

    // Active-high syncs on the second instance
    idle(4);
    run_frame(1, -1, -1, -1, -1, -1);
    run_frame(1, -1,  0,  0,  0, -1);
    run_frame(1, -1,  0,  0,  1, -1);
    chk_meas(1, "b_lock", 66, 48, 18, 12);
    run_frame(1, -1,  0,  1,  1, -1);

    idle(6);
    chk("a_queue_drained", qa.size(), 0);
    chk("b_queue_drained", qb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
